// File: rtl/pipelined_cpu.sv
// pipelined_cpu: three-stage pipeline with IF, ID/operand read and EX/writeback.
// It has a loadable instruction memory, a register file that resets to r[i] = i,
// EX->ID forwarding, a HALT opcode and an IDLE/RUN/HALTED control FSM.
//
// Instruction word, MSB first: {op[1:0], dest[RA_W], src1[RA_W], src2[RA_W]}
//   op 00 ADD, 01 SUB, 10 AND, 11 HALT
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       one-cycle pulse; starts execution at PC 0 from IDLE or HALTED
//   imem_we     instruction memory write enable (ignored while busy)
//   imem_addr   instruction memory write address
//   imem_wdata  instruction word to write
//   inst_out    instruction held in the ID/EX register (0 for a bubble)
//   pc_out      current fetch PC
//   wb_valid    one-cycle pulse for each register writeback
//   wb_addr     register written
//   wb_data     value written
//   busy        high in RUN
//   halted      high in HALTED
module pipelined_cpu #(
    parameter int DATA_W = 8,
    parameter int RA_W   = 2,
    parameter int PC_W   = 4,
    localparam int INST_W = 2 + 3 * RA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              imem_we,
    input  logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_wdata,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              wb_valid,
    output logic [RA_W-1:0]   wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              halted
);

    localparam int NREG  = 2 ** RA_W;
    localparam int IMEMD = 2 ** PC_W;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t state_q, state_d;

    logic [INST_W-1:0] imem [IMEMD];
    logic [DATA_W-1:0] regs [NREG];
    logic [PC_W-1:0]   pc;

    logic              vld_p0;
    logic [INST_W-1:0] inst_p0;
    logic              vld_p1;
    logic [INST_W-1:0] inst_p1;
    logic [DATA_W-1:0] opa_p1;
    logic [DATA_W-1:0] opb_p1;

    // ALU: modulo 2^DATA_W, so carry and borrow simply fall off the top.
    function automatic logic [DATA_W-1:0] alu(input logic [1:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        case (op)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_AND:  alu = a & b;
            default: alu = '0;
        endcase
    endfunction

    logic [1:0]        op_p0, op_p1;
    logic [RA_W-1:0]   src1_p0, src2_p0, dest_p1;
    logic              run, start_go, halt_p0, halt_p1, ex_wr, fetch_en;
    logic [DATA_W-1:0] ex_res, opa_id, opb_id;

    assign op_p0   = inst_p0[INST_W-1 -: 2];
    assign src1_p0 = inst_p0[2*RA_W-1 -: RA_W];
    assign src2_p0 = inst_p0[RA_W-1:0];
    assign op_p1   = inst_p1[INST_W-1 -: 2];
    assign dest_p1 = inst_p1[3*RA_W-1 -: RA_W];

    assign run      = (state_q == RUN);
    assign start_go = start && !run;
    assign halt_p0  = vld_p0 && (op_p0 == OP_HALT);
    assign halt_p1  = vld_p1 && (op_p1 == OP_HALT);
    assign ex_wr    = vld_p1 && (op_p1 != OP_HALT);
    assign ex_res   = alu(op_p1, opa_p1, opb_p1);
    // Once HALT is fetched nothing younger may enter; fetch stays off until
    // HALT leaves EX and the FSM drops out of RUN.
    assign fetch_en = run && !halt_p0 && !halt_p1;

    // The EX result is written to the regfile on the same edge ID reads it,
    // so a distance-1 dependency must bypass the regfile.
    assign opa_id = (ex_wr && dest_p1 == src1_p0) ? ex_res : regs[src1_p0];
    assign opb_id = (ex_wr && dest_p1 == src2_p0) ? ex_res : regs[src2_p0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = RUN;
            RUN:     if (halt_p1) state_d = HALTED;
            HALTED:  if (start)   state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc       <= '0;
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= DATA_W'(i);
        end else begin
            state_q <= state_d;
            if (start_go) begin
                pc     <= '0;
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
            end else if (run) begin
                // IF -> p0
                vld_p0 <= fetch_en;
                if (fetch_en) pc <= pc + PC_W'(1);
                // p0 -> p1 (ID/operand read)
                vld_p1 <= vld_p0;
            end else begin
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
            end
            // p1 -> writeback
            wb_valid <= ex_wr;
            wb_addr  <= ex_wr ? dest_p1 : '0;
            wb_data  <= ex_wr ? ex_res : '0;
            if (ex_wr) regs[dest_p1] <= ex_res;
        end
    end

    // Datapath registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (run) begin
            if (fetch_en) inst_p0 <= imem[pc];
            inst_p1 <= inst_p0;
            opa_p1  <= opa_id;
            opb_p1  <= opb_id;
        end
        if (imem_we && !run) imem[imem_addr] <= imem_wdata;
    end

    assign inst_out = vld_p1 ? inst_p1 : '0;
    assign pc_out   = pc;
    assign busy     = (state_q == RUN);
    assign halted   = (state_q == HALTED);

endmodule
